spram_bytewrite: RTL and testbench
==================================

// Module: spram_bytewrite
// PURPOSE
//  Single-port synchronous RAM with per-lane (byte) write enables and a configurable read pipeline.
//  Behaves as a read-first, zero-initialised memory, so one RTL model serves simulation and synthesis.
//  Used as the storage primitive under RAM wrappers such as caches, register files and buffers.
// PARAMETERS
//  ADDR_WIDTH    10  address bits; depth = 2**ADDR_WIDTH words
//  DATA_WIDTH    64  word width in bits
//  BYTE_WIDTH    8   write-lane width; DATA_WIDTH % BYTE_WIDTH == 0, else $error at elaboration
//  READ_LATENCY  1   read pipeline depth, 0..4; 0 = combinational read
//  Derived: LANES = DATA_WIDTH/BYTE_WIDTH
// PORTS
//  clk    in   1           rising-edge clock
//  rst    in   1           asynchronous, active-high reset; clears read pipeline only
//  en     in   1           port enable: gates both the write and the stage-0 read capture
//  addr   in   ADDR_WIDTH  word address
//  we     in   LANES       lane write strobes; we[i] covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH]
//  wdata  in   DATA_WIDTH  write data
//  regce  in   1           last-stage clock enable; port exists only with SPRAM_REGCE_EN
//  rdata  out  DATA_WIDTH  read data
// BEHAVIOUR
//  - Memory array powers up (initial block) as all-zero; rst never clears array contents.
//  - Write, on posedge clk with en=1:
//    - each lane i with we[i]=1 takes its wdata lane;
//    - unselected lanes keep their value;
//    - we=0 with en=1 is a pure read.
//  - Read-first: a read and write to the same addr in one cycle returns the OLD word.
//  - READ_LATENCY=0:
//    - rdata = mem[addr], combinational, independent of en/rst;
//    - a write becomes visible after the clock edge.
//  - READ_LATENCY=L>=1:
//    - stage0 <= mem[addr] when en=1, holds when en=0;
//    - stage k <= stage k-1 every cycle for 1<=k<L;
//    - rdata = stage L-1, so data appears L cycles after the addressed edge.
//  - rst=1 (async) forces every pipeline stage, and hence rdata, to 0 immediately.
//    - It holds them at 0 while asserted; writes with en=1 during rst still update memory.
//    - First valid read data follows L edges after rst deasserts.
//  - Address wrap: none needed; full ADDR_WIDTH space is valid.
//  - No X propagation from unwritten lanes, since the array is zero-initialised.
// CONFIGURATION
//  SPRAM_REGCE_EN defined:
//    - regce port present; last pipeline stage updates only when regce=1, otherwise holds;
//    - with L=1 regce gates stage0 together with en;
//    - ignored when L=0.
//  SPRAM_REGCE_EN undefined: no regce port; last stage behaves as if regce=1.
// STRUCTURE
//  - Package spram_pkg holds:
//    - default constants (SPRAM_ADDR_W=10, SPRAM_DATA_W=64, SPRAM_BYTE_W=8);
//    - function lanes(data_w, byte_w);
//    - generic typedefs for the default geometry (addr_t, word_t, lane-bundle union of word/lanes).
//  - Sub-module spram_read_pipe(WIDTH, LATENCY) implements the reset-able staging registers.
//    - The top holds the array, the lane write loop, and the latency-0 bypass.
// TESTING
//  1 L=1, en=1, we=all-1, addr=5, wdata=64'h0123_4567_89AB_CDEF; next cycle read addr 5
//    -> rdata=64'h0123_4567_89AB_CDEF one cycle later.
//  2 Lane write: mem[7]=64'hFFFF_FFFF_FFFF_FFFF; write we=8'b0000_0101, wdata=0
//    -> mem[7]=64'hFFFF_FFFF_FF00_FF00.
//  3 Read-first: mem[3]=64'hAA; same-cycle write 64'hBB to addr 3
//    -> rdata=64'hAA next cycle; reread gives 64'hBB.
//  4 L=2, en pulsed reading addr 1 (=1) then addr 2 (=2)
//    -> rdata 1 at edge+2, 2 at edge+3; en=0 freezes stage0.
//  5 Assert rst mid-stream (L=2)
//    -> rdata=0 immediately, without waiting for an edge; after release plus 2 edges, rdata=mem[addr].
//  6 Unwritten address 1023 at power-up -> rdata=0; with L=0, rdata follows addr combinationally.

Source files
------------

// File: rtl/spram_pkg.sv
// spram_pkg: shared constants, helpers and typedefs for the byte-writable
// single-port RAM family.
//   SPRAM_ADDR_W / SPRAM_DATA_W / SPRAM_BYTE_W : default geometry
//   lanes()        : number of write lanes for a given word/lane width
//   addr_t, word_t : address and word types for the default geometry
//   lane_bundle_t  : a word viewed either whole or as an array of lanes
package spram_pkg;

  localparam int SPRAM_ADDR_W = 10;
  localparam int SPRAM_DATA_W = 64;
  localparam int SPRAM_BYTE_W = 8;

  function automatic int lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  localparam int SPRAM_LANES = lanes(SPRAM_DATA_W, SPRAM_BYTE_W);

  typedef logic [SPRAM_ADDR_W-1:0] addr_t;
  typedef logic [SPRAM_DATA_W-1:0] word_t;
  typedef logic [SPRAM_LANES-1:0][SPRAM_BYTE_W-1:0] lanes_t;

  // Same bits, two views: .word for whole-word access, .lane[i] for lane i.
  typedef union packed {
    word_t  word;
    lanes_t lane;
  } lane_bundle_t;

endpackage

// File: rtl/spram_read_pipe.sv
// spram_read_pipe: read-data staging registers behind the RAM array.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears every stage
//   load  : stage-0 capture enable (the RAM port enable)
//   regce : last-stage clock enable (tie high when unused)
//   din   : word read from the array this cycle
//   dout  : output of the last stage
// LATENCY must be at least 1; the latency-0 bypass lives in the top.
module spram_read_pipe import spram_pkg::*; #(
  parameter int WIDTH   = SPRAM_DATA_W,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             regce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] stage_d;
    logic             stage_ce;

    if (gi == 0) begin : g_first
      assign stage_d = din;
      // A single-stage pipe is both first and last, so both enables apply.
      if (LATENCY == 1) begin : g_only
        assign stage_ce = load & regce;
      end else begin : g_head
        assign stage_ce = load;
      end
    end else begin : g_next
      assign stage_d = g_stage[gi-1].q_reg;
      if (gi == LATENCY - 1) begin : g_last
        assign stage_ce = regce;
      end else begin : g_mid
        assign stage_ce = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_reg <= '0;
      end else if (stage_ce) begin
        q_reg <= stage_d;
      end
    end
  end

  assign dout = g_stage[LATENCY-1].q_reg;

endmodule

// File: rtl/spram_bytewrite.sv
// spram_bytewrite: single-port, read-first RAM with per-lane write strobes
// and a 0..4 stage read pipeline. Contents start at zero and are never
// touched by reset; reset only clears the read pipeline.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset (read pipeline only)
//   en    : port enable, gates writes and the stage-0 read capture
//   addr  : word address
//   we    : lane write strobes, we[i] covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH]
//   wdata : write data
//   regce : last-stage clock enable, present only with SPRAM_REGCE_EN
//   rdata : read data
// Optional feature macro: SPRAM_REGCE_EN (adds the regce port).
module spram_bytewrite import spram_pkg::*; #(
  parameter int ADDR_WIDTH   = SPRAM_ADDR_W,
  parameter int DATA_WIDTH   = SPRAM_DATA_W,
  parameter int BYTE_WIDTH   = SPRAM_BYTE_W,
  parameter int READ_LATENCY = 1,
  localparam int LANES       = lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LANES-1:0]      we,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef SPRAM_REGCE_EN
  input  logic                  regce,
`endif
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_geometry
    $error("spram_bytewrite: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY < 0 || READ_LATENCY > 4) begin : g_bad_latency
    $error("spram_bytewrite: READ_LATENCY must be in 0..4");
  end

  // Declaration initialiser gives the all-zero power-up image in both
  // simulation and the FPGA bitstream.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  last_ce;

`ifdef SPRAM_REGCE_EN
  assign last_ce = regce;
`else
  assign last_ce = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) begin
          mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // The array read happens before the non-blocking write lands, so the
  // first pipeline stage captures the old word on a same-address write.
  assign rd_word = mem[addr];

  if (READ_LATENCY == 0) begin : g_comb_read
    assign rdata = rd_word;
  end else begin : g_pipe_read
    spram_read_pipe #(
      .WIDTH   (DATA_WIDTH),
      .LATENCY (READ_LATENCY)
    ) u_read_pipe (
      .clk   (clk),
      .rst   (rst),
      .load  (en),
      .regce (last_ce),
      .din   (rd_word),
      .dout  (rdata)
    );
  end

endmodule

// File: tb/tb_spram_bytewrite.sv
module tb_spram_bytewrite;
  import spram_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic [9:0]  addr;
  logic [7:0]  we;
  logic [63:0] wdata;
  logic        regce;
  logic [63:0] rdata0, rdata1, rdata2;

  int passed = 0;
  int total  = 0;

  // Reference: flat array of words plus the word each latency should show.
  word_t model_mem [1024];
  word_t m_cap;   // most recent word captured at an enabled edge
  word_t m_prev;  // the value m_cap had one edge earlier

  spram_bytewrite #(.READ_LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .we(we), .wdata(wdata),
`ifdef SPRAM_REGCE_EN
    .regce(regce),
`endif
    .rdata(rdata0));
  spram_bytewrite #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .we(we), .wdata(wdata),
`ifdef SPRAM_REGCE_EN
    .regce(regce),
`endif
    .rdata(rdata1));
  spram_bytewrite #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .we(we), .wdata(wdata),
`ifdef SPRAM_REGCE_EN
    .regce(regce),
`endif
    .rdata(rdata2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [9:0]  addr;
    logic [7:0]  we;
    logic [63:0] wdata;
    logic [63:0] exp_l0;
    logic [63:0] exp_l1;
    logic [63:0] exp_l2;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference behaviour at a clock edge, using the inputs currently driven.
  task automatic model_edge();
    lane_bundle_t cur, nw;
    cur.word = model_mem[addr];
    nw.word  = wdata;
    if (rst) begin
      m_cap  = '0;
      m_prev = '0;
    end else begin
      m_prev = m_cap;
      if (en) m_cap = cur.word;
    end
    if (en) begin
      for (int i = 0; i < 8; i++) if (we[i]) cur.lane[i] = nw.lane[i];
      model_mem[addr] = cur.word;
    end
  endtask

  task automatic step(input logic e, input logic [9:0] a, input logic [7:0] w, input logic [63:0] d);
    en = e; addr = a; we = w; wdata = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_l0"}, rdata0, model_mem[addr]);
    check({tag, "_l1"}, rdata1, m_cap);
    check({tag, "_l2"}, rdata2, m_prev);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    m_cap = '0; m_prev = '0;
    rst = 1'b1; en = 1'b0; addr = 10'd1023; we = '0; wdata = '0; regce = 1'b1;

    // Reset state and unwritten top address.
    repeat (2) @(posedge clk);
    #1;
    check("reset_l0_addr1023", rdata0, 64'h0);
    check("reset_l1", rdata1, 64'h0);
    check("reset_l2", rdata2, 64'h0);
    rst = 1'b0;

    // Directed table: lane writes, read-first, en hold, unwritten word.
    vecs[0]  = '{1'b1, 10'd5,    8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0};
    vecs[1]  = '{1'b1, 10'd5,    8'h00, 64'h0,                   64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[2]  = '{1'b1, 10'd7,    8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[3]  = '{1'b1, 10'd7,    8'h05, 64'h0,                   64'hFFFF_FFFF_FF00_FF00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[4]  = '{1'b1, 10'd7,    8'h00, 64'h0,                   64'hFFFF_FFFF_FF00_FF00, 64'hFFFF_FFFF_FF00_FF00, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5]  = '{1'b1, 10'd3,    8'hFF, 64'hAA,                  64'hAA, 64'h0, 64'hFFFF_FFFF_FF00_FF00};
    vecs[6]  = '{1'b1, 10'd3,    8'hFF, 64'hBB,                  64'hBB, 64'hAA, 64'h0};
    vecs[7]  = '{1'b1, 10'd3,    8'h00, 64'h0,                   64'hBB, 64'hBB, 64'hAA};
    vecs[8]  = '{1'b0, 10'd3,    8'hFF, 64'hCC,                  64'hBB, 64'hBB, 64'hBB};
    vecs[9]  = '{1'b0, 10'd1023, 8'h00, 64'h0,                   64'h0,  64'hBB, 64'hBB};
    vecs[10] = '{1'b1, 10'd1023, 8'h00, 64'h0,                   64'h0,  64'h0,  64'hBB};

    for (int v = 0; v < 11; v++) begin
      step(vecs[v].en, vecs[v].addr, vecs[v].we, vecs[v].wdata);
      $display("vec %0d en=%b addr=%0d we=%h wdata=%h rdata0=%h rdata1=%h rdata2=%h",
               v, en, addr, we, wdata, rdata0, rdata1, rdata2);
      check($sformatf("vec%0d_l0", v), rdata0, vecs[v].exp_l0);
      check($sformatf("vec%0d_l1", v), rdata1, vecs[v].exp_l1);
      check($sformatf("vec%0d_l2", v), rdata2, vecs[v].exp_l2);
    end

    // Two-stage pipe: en pulses then en low freezes stage 0.
    step(1'b1, 10'd1, 8'hFF, 64'd1);
    step(1'b1, 10'd2, 8'hFF, 64'd2);
    step(1'b1, 10'd1, 8'h00, 64'd0);   // addressed edge for word 1
    check("pipe_l2_old2", rdata2, 64'd0);
    step(1'b1, 10'd2, 8'h00, 64'd0);   // addressed edge for word 2
    check("pipe_l2_word1", rdata2, 64'd1);
    check("pipe_l1_word2", rdata1, 64'd2);
    step(1'b0, 10'd5, 8'h00, 64'd0);
    check("pipe_l2_word2", rdata2, 64'd2);
    check("pipe_l1_hold", rdata1, 64'd2);
    step(1'b0, 10'd7, 8'h00, 64'd0);
    check("pipe_l2_frozen", rdata2, 64'd2);

    // Async reset mid-stream, write under reset, recovery.
    step(1'b1, 10'd5, 8'h00, 64'd0);
    step(1'b1, 10'd7, 8'h00, 64'd0);
    check("prerst_l2", rdata2, 64'h0123_4567_89AB_CDEF);
    check("prerst_l1", rdata1, 64'hFFFF_FFFF_FF00_FF00);
    #2 rst = 1'b1;
    #1;
    check("async_rst_l1", rdata1, 64'h0);
    check("async_rst_l2", rdata2, 64'h0);
    m_cap = '0; m_prev = '0;
    step(1'b1, 10'd9, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
    check("rst_hold_l1", rdata1, 64'h0);
    check("rst_hold_l2", rdata2, 64'h0);
    check("rst_write_l0", rdata0, 64'hDEAD_BEEF_0BAD_F00D);
    rst = 1'b0;
    step(1'b1, 10'd9, 8'h00, 64'd0);
    check("rel1_l1", rdata1, 64'hDEAD_BEEF_0BAD_F00D);
    check("rel1_l2", rdata2, 64'h0);
    step(1'b1, 10'd9, 8'h00, 64'd0);
    check("rel2_l2", rdata2, 64'hDEAD_BEEF_0BAD_F00D);

    // Latency 0 follows addr with no clock edge.
    en = 1'b0; we = '0;
    addr = 10'd5; #1;
    check("comb_addr5", rdata0, 64'h0123_4567_89AB_CDEF);
    addr = 10'd7; #1;
    check("comb_addr7", rdata0, 64'hFFFF_FFFF_FF00_FF00);
    addr = 10'd1023; #1;
    check("comb_addr1023", rdata0, 64'h0);

    // Randomised traffic on a small address window to force collisions.
    for (int t = 0; t < 300; t++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), a, 8'($urandom), {$urandom, $urandom});
      $display("txn %0d en=%b addr=%0d we=%h wdata=%h rdata0=%h rdata1=%h rdata2=%h",
               t, en, addr, we, wdata, rdata0, rdata1, rdata2);
      check_all($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
